frame_select_ctrl: RTL
======================

Name: frame_select_ctrl

Overview:
- Consumes the 2 Hz frame-select clock produced by the frame clock divider, treating it as a slow asynchronous data input in the 50 MHz domain.
- Synchronises it and detects its rising edges.
- On each edge, runs a req/ack handshake with the audio capture buffer writer, then advances the displayed frame index.
- Supports freeze, overrun flagging and an ack timeout.

Parameters:
- NUM_FRAMES, 8, number of frame slots; frame_sel wraps from NUM_FRAMES-1 to 0; must be >= 2.
- FRAME_W, 3, width of frame_sel; must satisfy 2^FRAME_W >= NUM_FRAMES.
- ACK_TIMEOUT, 1000000, maximum clk_in cycles spent in REQ before the request is abandoned; must be >= 2.
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- clk_in  in  1  50 MHz system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_clk  in  1  2 Hz frame-select clock from the divider; asynchronous to clk_in, so it is synchronised internally.
- freeze  in  1  level input; high suppresses new requests.
- frame_ack  in  1  capture writer acknowledge; sampled only in REQ.
- clr_flags  in  1  one-cycle pulse; clears overrun and timeout.
- frame_req  out  1  request to the capture writer for a new frame.
- frame_sel  out  FRAME_W  current frame index.
- frame_tick  out  1  one-cycle pulse per detected frame_clk rising edge.
- overrun  out  1  sticky flag; a tick arrived while a request was outstanding.
- timeout  out  1  sticky flag; ack was not received within ACK_TIMEOUT cycles.

Behaviour:
- Reset (rst low, asynchronous):
  - sync flops, edge-history flop, frame_req, frame_tick, overrun, timeout and timeout counter = 0.
  - frame_sel = 0; state = IDLE.
  - Release is synchronous to clk_in.
- Synchroniser: two flops s1 -> s2, plus history flop s3.
  - frame_tick = s2 & !s3, registered.
  - A frame_clk rise setting up before edge N gives frame_tick high in the cycle after edge N+2.
  - frame_clk falls never produce a tick.
- State IDLE:
  - frame_tick & !freeze -> REQ next edge; frame_req = 1; timeout counter cleared.
  - frame_tick & freeze -> stay IDLE; tick discarded; no flag set.
- State REQ: frame_req held high; timeout counter increments each cycle.
  - frame_ack = 1 -> IDLE next edge.
    - Same edge: frame_req = 0.
    - Same edge: frame_sel = (frame_sel == NUM_FRAMES-1) ? 0 : frame_sel + 1.
  - Counter reaches ACK_TIMEOUT-1 with no ack -> IDLE; frame_req = 0; timeout = 1; frame_sel unchanged.
  - Ack and timeout in the same cycle: the ack wins; no timeout flag.
  - frame_tick in REQ: overrun = 1; tick dropped (not queued); request continues.
  - freeze rising in REQ: no effect; the request completes or times out normally.
- Back-to-back ticks: earliest next request is the cycle after the return to IDLE. There is no REQ->REQ path.
- Ack in IDLE: ignored.
- frame_req protocol: never deasserts before ack or timeout.
- Flags:
  - clr_flags clears overrun and timeout.
  - Set in the same cycle as clr_flags: the set wins.
- Reset mid-REQ: frame_req drops asynchronously; frame_sel returns to 0.
- frame_sel changes only on an accepted ack.

Decomposition:
- Shared package (frame_pkg):
  - state encodings IDLE = 1'b0, REQ = 1'b1.
  - default NUM_FRAMES and ACK_TIMEOUT constants, shared with the frame clock divider and capture writer.
- Sub-module sync_edge_det:
  - 2-flop synchroniser plus rising-edge pulse, parameterless.
  - Reused for button inputs elsewhere.

Test Plan:
- Reset then frame_clk 0->1 (held 10 cycles) -> frame_tick one pulse, 3 cycles after the first sampling edge; frame_req rises the next cycle; frame_sel = 0.
- Ack 4 cycles after frame_req for 9 frames (NUM_FRAMES=8) -> frame_sel 1,2,...,7,0,1; frame_req low the cycle after each ack.
- freeze=1 during a frame_clk rise -> no frame_req; frame_sel and flags unchanged.
- ACK_TIMEOUT=16, no ack -> frame_req high exactly 16 cycles, then low; timeout = 1; frame_sel unchanged; clr_flags -> timeout = 0.
- Second frame_clk rise while REQ is outstanding -> overrun = 1; only one frame_sel increment after the ack. clr_flags coincident with a new overrun -> overrun stays 1.
- rst low mid-REQ with frame_sel = 5 -> frame_req = 0 and frame_sel = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the frame-select path: controller state encoding,
// default frame/timeout constants and the frame index wrap helper.
package frame_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int NUM_FRAMES_DEF  = 8;
  localparam int ACK_TIMEOUT_DEF = 1000000;

  // Next frame slot, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for a slow asynchronous level, followed by a
// registered one-cycle pulse on each synchronised rising edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 form the metastability guard; s3 holds the previous settled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/frame_select_ctrl.sv
// Frame-select controller: turns each frame_clk rising edge into a req/ack
// handshake with the capture writer and advances frame_sel on each ack.
module frame_select_ctrl
  import frame_pkg::*;
#(
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int FRAME_W     = 3,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int TO_W        = 20
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               frame_clk,
  input  logic               freeze,
  input  logic               frame_ack,
  input  logic               clr_flags,
  output logic               frame_req,
  output logic [FRAME_W-1:0] frame_sel,
  output logic               frame_tick,
  output logic               overrun,
  output logic               timeout
);

  // Handshake: frame_req rises on an accepted tick and stays high until the
  // cycle frame_ack is sampled high or the timeout expires; frame_ack is only
  // looked at while the request is outstanding.
  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            in_req;
  logic            ack_ok;
  logic            to_hit;
  logic            set_ov;

  sync_edge_det u_sync (
    .clk   (clk_in),
    .rst_n (rst),
    .din   (frame_clk),
    .rise  (frame_tick)
  );

  assign in_req = (state == REQ);
  assign ack_ok = in_req && frame_ack;
  // An ack in the final counted cycle still completes the frame.
  assign to_hit = in_req && !frame_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign set_ov = in_req && frame_tick;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      frame_req <= 1'b0;
      frame_sel <= '0;
      to_cnt    <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      overrun <= set_ov | (overrun & ~clr_flags);
      timeout <= to_hit | (timeout & ~clr_flags);
      case (state)
        IDLE: begin
          if (frame_tick && !freeze) begin
            state     <= REQ;
            frame_req <= 1'b1;
            to_cnt    <= '0;
          end
        end
        REQ: begin
          to_cnt <= to_cnt + 1'b1;
          if (ack_ok) begin
            state     <= IDLE;
            frame_req <= 1'b0;
            frame_sel <= FRAME_W'(wrap_inc(32'(frame_sel), NUM_FRAMES));
          end else if (to_hit) begin
            state     <= IDLE;
            frame_req <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          frame_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
